// File: rtl/vin_lm75_target.sv
// LM75-compatible I2C target: filtered SCL/SDA front end, byte-level protocol FSM,
// and the CONF/THYST/TOS register file, plus a TEMP snapshot for coherent reads.
module vin_lm75_target #(
   parameter logic [6:0]  ADDRESS   = 7'b1001000,
   parameter logic [15:0] RST_THYST = 16'h4B00,
   parameter logic [15:0] RST_TOS   = 16'h5000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   input  logic [15:0] temp_in,
   output logic [7:0]  conf_out,
   output logic [15:0] thyst_out,
   output logic [15:0] tos_out,
   output logic        wr_strobe,
   output logic        busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
   } state_t;

   logic [1:0]  scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic [2:0]  scl_hist_q, scl_hist_d, sda_hist_q, sda_hist_d;
   logic        scl_f_q, scl_f_d, sda_f_q, sda_f_d;
   logic        scl_f, sda_f, scl_rise, scl_fall, start_evt, stop_evt;

   state_t      state_q, state_d;
   logic [3:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d, tx_q, tx_d, msb_buf_q, msb_buf_d;
   logic [7:0]  conf_q, conf_d, rd_byte;
   logic [15:0] thyst_q, thyst_d, tos_q, tos_d, temp_shadow_q, temp_shadow_d;
   logic [1:0]  ptr_q, ptr_d;
   logic        sda_oe_q, sda_oe_d, busy_q, busy_d, rw_q, rw_d;
   logic        ptr_phase_q, ptr_phase_d, msb_pending_q, msb_pending_d;
   logic        rd_lsb_q, rd_lsb_d, nack_q, nack_d, wr_strobe_q, wr_strobe_d;
   logic        load_rd;

   // Two-flop synchroniser feeding a three-sample majority vote per line.
   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl_in};
      sda_sync_d = {sda_sync_q[0], sda_in};
      scl_hist_d = {scl_hist_q[1:0], scl_sync_q[1]};
      sda_hist_d = {sda_hist_q[1:0], sda_sync_q[1]};
      scl_f = (scl_hist_q[0] & scl_hist_q[1]) | (scl_hist_q[0] & scl_hist_q[2]) |
              (scl_hist_q[1] & scl_hist_q[2]);
      sda_f = (sda_hist_q[0] & sda_hist_q[1]) | (sda_hist_q[0] & sda_hist_q[2]) |
              (sda_hist_q[1] & sda_hist_q[2]);
      scl_f_d   = scl_f;
      sda_f_d   = sda_f;
      scl_rise  = scl_f & ~scl_f_q;
      scl_fall  = ~scl_f & scl_f_q;
      start_evt = scl_f & scl_f_q & sda_f_q & ~sda_f;
      stop_evt  = scl_f & scl_f_q & ~sda_f_q & sda_f;
   end

   always_comb begin
      unique case (ptr_q)
         2'd0:    rd_byte = rd_lsb_q ? temp_shadow_q[7:0] : temp_in[15:8];
         2'd1:    rd_byte = conf_q;
         2'd2:    rd_byte = rd_lsb_q ? thyst_q[7:0] : thyst_q[15:8];
         default: rd_byte = rd_lsb_q ? tos_q[7:0] : tos_q[15:8];
      endcase
   end

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      tx_d          = tx_q;
      msb_buf_d     = msb_buf_q;
      conf_d        = conf_q;
      thyst_d       = thyst_q;
      tos_d         = tos_q;
      temp_shadow_d = temp_shadow_q;
      ptr_d         = ptr_q;
      sda_oe_d      = sda_oe_q;
      busy_d        = busy_q;
      rw_d          = rw_q;
      ptr_phase_d   = ptr_phase_q;
      msb_pending_d = msb_pending_q;
      rd_lsb_d      = rd_lsb_q;
      nack_d        = nack_q;
      wr_strobe_d   = 1'b0;
      load_rd       = 1'b0;
      if (start_evt) begin
         state_d       = ADDR;
         bit_cnt_d     = 4'd0;
         sda_oe_d      = 1'b0;
         busy_d        = 1'b0;
         rd_lsb_d      = 1'b0;
         msb_pending_d = 1'b0;
      end else if (stop_evt) begin
         state_d       = IDLE;
         sda_oe_d      = 1'b0;
         busy_d        = 1'b0;
         msb_pending_d = 1'b0;
      end else begin
         case (state_q)
            ADDR: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_f};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  if (shift_q[7:1] == ADDRESS) begin
                     state_d  = ADDR_ACK;
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                     rw_d     = shift_q[0];
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  if (rw_q) begin
                     load_rd = 1'b1;
                  end else begin
                     state_d     = WR_BYTE;
                     bit_cnt_d   = 4'd0;
                     ptr_phase_d = 1'b1;
                  end
               end
            end
            WR_BYTE: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_f};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  state_d  = WR_ACK;
                  sda_oe_d = 1'b1;
                  if (ptr_phase_q) begin
                     ptr_d         = shift_q[1:0];
                     ptr_phase_d   = 1'b0;
                     msb_pending_d = 1'b0;
                  end else if (ptr_q == 2'd1) begin
                     conf_d      = shift_q;
                     wr_strobe_d = 1'b1;
                  end else if (ptr_q != 2'd0) begin
                     // 16-bit registers only change once both halves have arrived.
                     if (!msb_pending_q) begin
                        msb_buf_d     = shift_q;
                        msb_pending_d = 1'b1;
                     end else begin
                        if (ptr_q == 2'd2) thyst_d = {msb_buf_q, shift_q};
                        else               tos_d   = {msb_buf_q, shift_q};
                        wr_strobe_d   = 1'b1;
                        msb_pending_d = 1'b0;
                     end
                  end
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d  = 1'b0;
                  state_d   = WR_BYTE;
                  bit_cnt_d = 4'd0;
               end
            end
            RD_BYTE: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     state_d  = RD_ACK;
                     sda_oe_d = 1'b0;
                  end else begin
                     sda_oe_d = ~tx_q[7];
                     tx_d     = {tx_q[6:0], 1'b0};
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  nack_d = sda_f;
               end else if (scl_fall) begin
                  if (nack_q) state_d = IGNORE;
                  else        load_rd = 1'b1;
               end
            end
            default: sda_oe_d = 1'b0;
         endcase
         // First bit of each read byte goes out on the same SCL fall that loads it.
         if (load_rd) begin
            state_d   = RD_BYTE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = ~rd_byte[7];
            tx_d      = {rd_byte[6:0], 1'b0};
            if (ptr_q != 2'd1) rd_lsb_d = ~rd_lsb_q;
            if (ptr_q == 2'd0 && !rd_lsb_q) temp_shadow_d = temp_in;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q    <= 2'b11;
         sda_sync_q    <= 2'b11;
         scl_hist_q    <= 3'b111;
         sda_hist_q    <= 3'b111;
         scl_f_q       <= 1'b1;
         sda_f_q       <= 1'b1;
         state_q       <= IDLE;
         bit_cnt_q     <= 4'd0;
         shift_q       <= 8'h00;
         tx_q          <= 8'h00;
         msb_buf_q     <= 8'h00;
         conf_q        <= 8'h00;
         thyst_q       <= RST_THYST;
         tos_q         <= RST_TOS;
         temp_shadow_q <= 16'h0000;
         ptr_q         <= 2'd0;
         sda_oe_q      <= 1'b0;
         busy_q        <= 1'b0;
         rw_q          <= 1'b0;
         ptr_phase_q   <= 1'b0;
         msb_pending_q <= 1'b0;
         rd_lsb_q      <= 1'b0;
         nack_q        <= 1'b0;
         wr_strobe_q   <= 1'b0;
      end else begin
         scl_sync_q    <= scl_sync_d;
         sda_sync_q    <= sda_sync_d;
         scl_hist_q    <= scl_hist_d;
         sda_hist_q    <= sda_hist_d;
         scl_f_q       <= scl_f_d;
         sda_f_q       <= sda_f_d;
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         tx_q          <= tx_d;
         msb_buf_q     <= msb_buf_d;
         conf_q        <= conf_d;
         thyst_q       <= thyst_d;
         tos_q         <= tos_d;
         temp_shadow_q <= temp_shadow_d;
         ptr_q         <= ptr_d;
         sda_oe_q      <= sda_oe_d;
         busy_q        <= busy_d;
         rw_q          <= rw_d;
         ptr_phase_q   <= ptr_phase_d;
         msb_pending_q <= msb_pending_d;
         rd_lsb_q      <= rd_lsb_d;
         nack_q        <= nack_d;
         wr_strobe_q   <= wr_strobe_d;
      end
   end

   assign sda_oe    = sda_oe_q;
   assign busy      = busy_q;
   assign wr_strobe = wr_strobe_q;
   assign conf_out  = conf_q;
   assign thyst_out = thyst_q;
   assign tos_out   = tos_q;

endmodule
